// File: rtl/score_display.sv
// rtl/score_display.sv - two-score double-dabble BCD converter with 4-digit multiplexed 7-segment driver; define SCORE_BLANK_ZERO_EN to blank zero tens digits
module score_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] scoreX,
    input  logic [5:0] scoreO,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       conv_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t      state_q;
    logic [2:0]  shift_cnt_q;
    // working register layout: {tens[3:0], ones[3:0], binary[5:0]}
    logic [13:0] work_x_q, work_x_d;
    logic [13:0] work_o_q, work_o_d;
    logic [7:0]  disp_x_q, disp_o_q;
    logic        conv_done_q;

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    digit;

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
    function automatic logic [13:0] dd_step(input logic [13:0] w);
        logic [3:0] t;
        logic [3:0] o;
        t = w[13:10];
        o = w[9:6];
        if (o >= 4'd5) o = o + 4'd3;
        if (t >= 4'd5) t = t + 4'd3;
        return {t[2:0], o, w[5:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Next working values while shifting
    always_comb begin
        work_x_d = dd_step(work_x_q);
        work_o_d = dd_step(work_o_q);
    end

    // Conversion FSM: IDLE -> LOAD -> SHIFT x6 -> LATCH, free-running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_cnt_q <= 3'd0;
            work_x_q    <= 14'd0;
            work_o_q    <= 14'd0;
            disp_x_q    <= 8'd0;
            disp_o_q    <= 8'd0;
            conv_done_q <= 1'b0;
        end else begin
            conv_done_q <= 1'b0;
            case (state_q)
                IDLE: state_q <= LOAD;
                LOAD: begin
                    work_x_q    <= {8'd0, scoreX};
                    work_o_q    <= {8'd0, scoreO};
                    shift_cnt_q <= 3'd0;
                    state_q     <= SHIFT;
                end
                SHIFT: begin
                    work_x_q    <= work_x_d;
                    work_o_q    <= work_o_d;
                    shift_cnt_q <= shift_cnt_q + 3'd1;
                    if (shift_cnt_q == 3'd5) state_q <= LATCH;
                end
                LATCH: begin
                    disp_x_q    <= work_x_q[13:6];
                    disp_o_q    <= work_o_q[13:6];
                    conv_done_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Select the digit for the current scan index and encode it
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        case (idx_q)
            2'd3:    digit = disp_x_q[7:4];
            2'd2:    digit = disp_x_q[3:0];
            2'd1:    digit = disp_o_q[7:4];
            default: digit = disp_o_q[3:0];
        endcase
        if (active_q) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_enc(digit);
`ifdef SCORE_BLANK_ZERO_EN
            // odd indices are the tens positions
            if (idx_q[0] && (digit == 4'd0)) seg_d = 7'b1111111;
`endif
        end
    end

    // Refresh counter, scan index and registered display outputs; scanning waits for the first latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= 2'd3;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
        end else begin
            if (state_q == LATCH) active_q <= 1'b1;
            if (active_q) begin
                if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                    cnt_q <= '0;
                    idx_q <= idx_q - 2'd1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign conv_done = conv_done_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed table-driven bench for score_display with REFRESH_DIV=4
module tb_score_display;

    logic       clk;
    logic       rst_n;
    logic [5:0] scoreX;
    logic [5:0] scoreO;
    logic [3:0] an;
    logic [6:0] seg;
    logic       conv_done;

    int tests;
    int fails;

    score_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scoreX    (scoreX),
        .scoreO    (scoreO),
        .an        (an),
        .seg       (seg),
        .conv_done (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  o;
        logic [15:0] digits;   // {X tens, X ones, O tens, O ones}, hand-computed
    } vec_t;

    vec_t vecs[6];

    function automatic logic [6:0] exp_seg(input logic [3:0] d, input bit tens);
`ifdef SCORE_BLANK_ZERO_EN
        if (tens && d == 4'd0) return 7'b1111111;
`endif
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int slot);
        logic [3:0] a;
        a = 4'b1111;
        a[3 - slot] = 1'b0;
        return a;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset with the given scores, release, and expect the first conv_done 9 edges later
    task automatic do_start(input logic [5:0] x, input logic [5:0] o, output bit ok);
        int cyc;
        rst_n  = 1'b0;
        scoreX = x;
        scoreO = o;
        repeat (2) @(negedge clk);
        check("reset_an", {12'd0, an}, 16'h000f);
        check("reset_seg", {9'd0, seg}, 16'h007f);
        check("reset_conv_done", {15'd0, conv_done}, 16'h0000);
        rst_n = 1'b1;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (conv_done) begin
                ok = 1'b1;
                break;
            end
            check("an_blank_before_done", {12'd0, an}, 16'h000f);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL conv_done_timeout: got none in %0d cycles, expected one", cyc);
        end else begin
            check("first_done_latency", 16'(cyc), 16'd9);
            check("an_at_first_done", {12'd0, an}, 16'h000f);
        end
    endtask

    // Follow one full scan after the first conv_done with steady inputs
    task automatic scan_check(input logic [15:0] digits, input int ncyc);
        int slot;
        logic [3:0] d;
        for (int p = 1; p <= ncyc; p++) begin
            @(negedge clk);
            slot = ((p - 1) / 4) % 4;
            d = digits[15 - 4*slot -: 4];
            check("scan_an", {12'd0, an}, {12'd0, exp_an(slot)});
            check("scan_seg", {9'd0, seg}, {9'd0, exp_seg(d, (slot == 0) || (slot == 2))});
            check("conv_done_pulse", {15'd0, conv_done}, {15'd0, (p % 9) == 0});
        end
    endtask

    initial begin
        bit ok;
        int slot;
        logic [3:0] d;

        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        scoreX = 6'd0;
        scoreO = 6'd0;

        vecs[0] = '{x: 6'd0,  o: 6'd0,  digits: 16'h0000};
        vecs[1] = '{x: 6'd37, o: 6'd9,  digits: 16'h3709};
        vecs[2] = '{x: 6'd63, o: 6'd5,  digits: 16'h6305};
        vecs[3] = '{x: 6'd10, o: 6'd59, digits: 16'h1059};
        vecs[4] = '{x: 6'd48, o: 6'd26, digits: 16'h4826};
        vecs[5] = '{x: 6'd1,  o: 6'd40, digits: 16'h0140};

        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].x, vecs[i].o, ok);
            if (ok) scan_check(vecs[i].digits, 18);
        end

        // Input change during SHIFT: conversion in flight keeps 63, the next one shows 12
        do_start(6'd63, 6'd0, ok);
        if (ok) begin
            for (int p = 1; p <= 24; p++) begin
                @(negedge clk);
                slot = ((p - 1) / 4) % 4;
                if (p <= 4 || p == 17 || p == 18) d = 4'd6;
                else if (p <= 8)                  d = 4'd3;
                else if (p <= 16)                 d = 4'd0;
                else if (p <= 20)                 d = 4'd1;
                else                              d = 4'd2;
                check("midshift_an", {12'd0, an}, {12'd0, exp_an(slot)});
                check("midshift_seg", {9'd0, seg}, {9'd0, exp_seg(d, (slot == 0) || (slot == 2))});
                if (p == 3) scoreX = 6'd12;
            end
        end

        // Asynchronous reset during SHIFT, then a clean restart
        do_start(6'd37, 6'd9, ok);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_an", {12'd0, an}, 16'h000f);
        check("async_rst_seg", {9'd0, seg}, 16'h007f);
        check("async_rst_conv_done", {15'd0, conv_done}, 16'h0000);
        do_start(6'd20, 6'd47, ok);
        if (ok) scan_check(16'h2047, 18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
